// File: rtl/mem_stage_if.sv
// ============================================================================
// mem_stage_if : EX/MEM inputs and MEM/WB outputs of the MEM pipeline stage
// Revision 1.0
// ============================================================================
`default_nettype none

interface mem_stage_if;
   logic [31:0] IR_MEM;
   logic [31:0] PC4_MEM;
   logic [31:0] AO_MEM;
   logic [31:0] RD2_MEM;
   logic [31:0] IR_WB;
   logic [31:0] PC4_WB;
   logic [31:0] AO_WB;
   logic [31:0] DR_WB;
   logic [1:0]  EXC_WB;

   modport master (
      output IR_MEM, PC4_MEM, AO_MEM, RD2_MEM,
      input  IR_WB, PC4_WB, AO_WB, DR_WB, EXC_WB
   );

   modport slave (
      input  IR_MEM, PC4_MEM, AO_MEM, RD2_MEM,
      output IR_WB, PC4_WB, AO_WB, DR_WB, EXC_WB
   );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : MIPS MEM stage with byte-lane data memory and MEM/WB register
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
   parameter int          DM_WORDS = 1024,
   parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
   input  wire logic      CLK,
   input  wire logic      reset,
   mem_stage_if.slave     bus
);

   localparam int          AW       = $clog2(DM_WORDS);
   localparam logic [32:0] DM_BYTES = 33'(DM_WORDS) * 33'd4;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [1:0] EXC_NONE = 2'd0;
   localparam logic [1:0] EXC_ADEL = 2'd1;
   localparam logic [1:0] EXC_ADES = 2'd2;

   logic [31:0]   mem [DM_WORDS];

   logic          is_load;
   logic          is_store;
   logic          zero_ext;
   logic [1:0]    size;
   logic [31:0]   offset;
   logic          in_range;
   logic          misaligned;
   logic          fault;
   logic [1:0]    lane;
   logic [AW-1:0] word_idx;
   logic          write_en;
   logic [3:0]    byte_en;
   logic [31:0]   write_data;
   logic [31:0]   read_word;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;
   logic [31:0]   load_ext;
   logic [31:0]   dr_next;
   logic [1:0]    exc_next;

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      zero_ext = 1'b0;
      size     = SZ_W;
      unique case (bus.IR_MEM[31:26])
         OP_LB:   begin is_load  = 1'b1; size = SZ_B; end
         OP_LH:   begin is_load  = 1'b1; size = SZ_H; end
         OP_LW:   begin is_load  = 1'b1; size = SZ_W; end
         OP_LBU:  begin is_load  = 1'b1; size = SZ_B; zero_ext = 1'b1; end
         OP_LHU:  begin is_load  = 1'b1; size = SZ_H; zero_ext = 1'b1; end
         OP_SB:   begin is_store = 1'b1; size = SZ_B; end
         OP_SH:   begin is_store = 1'b1; size = SZ_H; end
         OP_SW:   begin is_store = 1'b1; size = SZ_W; end
         default: ;
      endcase
   end

   // Range is checked on the full wrapped offset so addresses below DM_BASE fault too.
   assign offset     = bus.AO_MEM - DM_BASE;
   assign in_range   = ({1'b0, offset} < DM_BYTES);
   assign word_idx   = offset[AW+1:2];
   assign lane       = bus.AO_MEM[1:0];
   assign misaligned = ((size == SZ_W) && (lane != 2'b00)) ||
                       ((size == SZ_H) && lane[0]);
   assign fault      = !in_range || misaligned;
   assign write_en   = is_store && !fault;

   always_comb begin
      byte_en    = 4'b1111;
      write_data = bus.RD2_MEM;
      unique case (size)
         SZ_B: begin
            byte_en    = 4'b0001 << lane;
            write_data = {4{bus.RD2_MEM[7:0]}};
         end
         SZ_H: begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            write_data = {2{bus.RD2_MEM[15:0]}};
         end
         default: ;
      endcase
   end

   // Not reset: contents survive reset; writes are suppressed while reset is low.
   always_ff @(posedge CLK) begin
      if (reset && write_en) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
               mem[word_idx][8*i +: 8] <= write_data[8*i +: 8];
            end
         end
      end
   end

   assign read_word = mem[word_idx];

   always_comb begin
      ld_byte  = read_word[{lane, 3'b000} +: 8];
      ld_half  = lane[1] ? read_word[31:16] : read_word[15:0];
      load_ext = read_word;
      unique case (size)
         SZ_B:    load_ext = {{24{!zero_ext && ld_byte[7]}}, ld_byte};
         SZ_H:    load_ext = {{16{!zero_ext && ld_half[15]}}, ld_half};
         default: ;
      endcase
   end

   always_comb begin
      dr_next  = 32'd0;
      exc_next = EXC_NONE;
      if (is_load) begin
         if (fault) exc_next = EXC_ADEL;
         else       dr_next  = load_ext;
      end else if (is_store && fault) begin
         exc_next = EXC_ADES;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         bus.IR_WB  <= 32'd0;
         bus.PC4_WB <= 32'd0;
         bus.AO_WB  <= 32'd0;
         bus.DR_WB  <= 32'd0;
         bus.EXC_WB <= EXC_NONE;
      end else begin
         bus.IR_WB  <= bus.IR_MEM;
         bus.PC4_WB <= bus.PC4_MEM;
         bus.AO_WB  <= bus.AO_MEM;
         bus.DR_WB  <= dr_next;
         bus.EXC_WB <= exc_next;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : scoreboard bench for mem_stage against a byte-addressed model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

   localparam int          DM_WORDS = 1024;
   localparam logic [31:0] DM_BASE  = 32'h0000_0000;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] pc4;
      logic [31:0] ao;
      logic [31:0] dr;
      logic [1:0]  exc;
   } exp_t;

   logic clk;
   logic reset;
   int   vectors = 0;
   int   errors  = 0;
   logic [31:0] pc_cnt = 32'h0000_1000;

   exp_t       exp_q[$];
   logic [7:0] bmem[int];

   mem_stage_if bus();

   mem_stage #(.DM_WORDS(DM_WORDS), .DM_BASE(DM_BASE)) dut (
      .CLK   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
         errors++;
      end
   endtask

   // Reference: memory is a map of bytes; an access of n bytes touches offset..offset+n-1.
   function automatic void model(input logic [31:0] ir, input logic [31:0] ao,
                                 input logic [31:0] rd2,
                                 output logic [31:0] dr, output logic [1:0] exc);
      int          n = 0;
      bit          ld = 0, sgn = 0, flt;
      logic [31:0] off, v;
      case (ir[31:26])
         6'b100000: begin ld = 1; n = 1; sgn = 1; end
         6'b100001: begin ld = 1; n = 2; sgn = 1; end
         6'b100011: begin ld = 1; n = 4; end
         6'b100100: begin ld = 1; n = 1; end
         6'b100101: begin ld = 1; n = 2; end
         6'b101000: n = 1;
         6'b101001: n = 2;
         6'b101011: n = 4;
         default:   n = 0;
      endcase
      dr  = 32'd0;
      exc = 2'd0;
      if (n == 0) return;
      off = ao - DM_BASE;
      flt = ((ao % n) != 0) || (off >= DM_WORDS * 4);
      if (ld) begin
         if (flt) begin
            exc = 2'd1;
         end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) begin
               if (bmem.exists(int'(off) + k))
                  v = v | (32'(bmem[int'(off) + k]) << (8 * k));
            end
            if (sgn && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            dr = v;
         end
      end else begin
         if (flt) exc = 2'd2;
         else
            for (int k = 0; k < n; k++) bmem[int'(off) + k] = 8'(rd2 >> (8 * k));
      end
   endfunction

   task automatic issue(input logic [31:0] ir, input logic [31:0] ao, input logic [31:0] rd2);
      exp_t e;
      @(negedge clk);
      pc_cnt += 4;
      bus.IR_MEM  = ir;
      bus.PC4_MEM = pc_cnt;
      bus.AO_MEM  = ao;
      bus.RD2_MEM = rd2;
      e.ir  = ir;
      e.pc4 = pc_cnt;
      e.ao  = ao;
      model(ir, ao, rd2, e.dr, e.exc);
      exp_q.push_back(e);
   endtask

   // Store whose capturing edge happens while reset is low: nothing may be written.
   task automatic issue_store_under_reset(input logic [31:0] ao, input logic [31:0] rd2);
      exp_t e;
      @(negedge clk);
      pc_cnt += 4;
      bus.IR_MEM  = {6'b101011, 26'h0};
      bus.PC4_MEM = pc_cnt;
      bus.AO_MEM  = ao;
      bus.RD2_MEM = rd2;
      e = '{32'd0, 32'd0, 32'd0, 32'd0, 2'd0};
      exp_q.push_back(e);
      #4 reset = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
         errors++;
         exp_q.delete();
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op);
      return {op, 26'($urandom)};
   endfunction

   // Monitor: one MEM/WB result per issued instruction, one edge after it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            chk("IR_WB",  bus.IR_WB,  e.ir);
            chk("PC4_WB", bus.PC4_WB, e.pc4);
            chk("AO_WB",  bus.AO_WB,  e.ao);
            chk("DR_WB",  bus.DR_WB,  e.dr);
            chk("EXC_WB", 32'(bus.EXC_WB), 32'(e.exc));
         end
      end
   end

   initial begin
      logic [5:0]  ops[9];
      logic [5:0]  op;
      logic [31:0] addr;
      ops = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
              6'b101000, 6'b101001, 6'b101011, 6'b000000};
      reset       = 1'b0;
      bus.IR_MEM  = 32'd0;
      bus.PC4_MEM = 32'd0;
      bus.AO_MEM  = 32'd0;
      bus.RD2_MEM = 32'd0;
      #1;
      vectors++;
      chk("reset_IR",  bus.IR_WB,  32'd0);
      chk("reset_DR",  bus.DR_WB,  32'd0);
      chk("reset_EXC", 32'(bus.EXC_WB), 32'd0);
      @(negedge clk);
      #2 reset = 1'b1;

      // Known contents in the test window
      for (int w = 0; w < 16; w++) issue({6'b101011, 26'h0}, DM_BASE + 32'(w * 4), 32'd0);

      // Word round-trip, partial stores
      issue({6'b101011, 26'h0}, 32'h10, 32'hDEAD_BEEF);
      issue({6'b100011, 26'h0}, 32'h10, 32'h0);
      issue({6'b101000, 26'h0}, 32'h11, 32'h55);
      issue({6'b101001, 26'h0}, 32'h12, 32'h1234);
      issue({6'b100011, 26'h0}, 32'h10, 32'h0);
      issue({6'b100000, 26'h0}, 32'h11, 32'h0);
      issue({6'b100001, 26'h0}, 32'h12, 32'h0);

      // Extension
      issue({6'b101011, 26'h0}, 32'h20, 32'h8081_F0FF);
      issue({6'b100000, 26'h0}, 32'h20, 32'h0);
      issue({6'b100100, 26'h0}, 32'h20, 32'h0);
      issue({6'b100001, 26'h0}, 32'h22, 32'h0);
      issue({6'b100101, 26'h0}, 32'h22, 32'h0);

      // Faults and non-memory
      issue({6'b101011, 26'h0}, 32'h00, 32'hCAFE_F00D);
      issue({6'b100011, 26'h0}, 32'h13, 32'h0);
      issue({6'b101001, 26'h0}, 32'h15, 32'hFFFF);
      issue({6'b100011, 26'h0}, 32'h14, 32'h0);
      issue({6'b101011, 26'h0}, DM_BASE + DM_WORDS * 4, 32'h1111_1111);
      issue({6'b100011, 26'h0}, 32'h00, 32'h0);
      issue(32'h0000_0000, 32'h0, 32'h0);
      issue(32'h0085_1021, 32'h3, 32'hFFFF_FFFF);
      issue({6'b100011, 26'h0}, 32'h00, 32'h0);
      drain();

      // Asynchronous reset mid-cycle
      @(negedge clk);
      bus.IR_MEM = 32'd0;
      #2 reset = 1'b0;
      #1;
      vectors++;
      chk("async_IR",  bus.IR_WB,  32'd0);
      chk("async_PC4", bus.PC4_WB, 32'd0);
      chk("async_AO",  bus.AO_WB,  32'd0);
      chk("async_DR",  bus.DR_WB,  32'd0);
      #1 reset = 1'b1;
      issue({6'b101011, 26'h0}, 32'h10, 32'h0);
      issue_store_under_reset(32'h10, 32'hDEAD_BEEF);
      issue({6'b100011, 26'h0}, 32'h10, 32'h0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         op = ops[$urandom_range(0, 8)];
         case ($urandom_range(0, 9))
            0:       addr = DM_BASE + DM_WORDS * 4 + 32'($urandom_range(0, 63));
            1:       addr = DM_BASE - 32'($urandom_range(1, 8));
            default: addr = DM_BASE + 32'($urandom_range(0, 63));
         endcase
         issue(mk(op), addr, $urandom);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
